// File: rtl/flit_packetizer.sv
// Packetizer: turns a request plus payload words into 1-2 header flits followed by data flits.
// Headers appear the cycle after accept; data passes straight through; flit_ready stalls everything.
package flit_packetizer_pkg;
    typedef struct packed {
        logic        vc;
        logic [1:0]  id;
        logic [4:0]  req;
        logic [31:0] payload;
    } flit_t;
endpackage

module flit_packetizer
    import flit_packetizer_pkg::*;
#(
    parameter logic [4:0] NODE_ID   = 5'd0,
    parameter logic       VC        = 1'b0,
    parameter logic [3:0] FMT_LONG  = 4'h1,
    parameter logic [3:0] FMT_SHORT = 4'h2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_dest,
    input  logic [29:0] req_addr,
    input  logic [6:0]  req_len,
    input  logic [3:0]  req_fst_b,
    input  logic [3:0]  req_lst_b,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [31:0] data_word,
    output logic        flit_valid,
    input  logic        flit_ready,
    output flit_t       flit,
    output logic        pkt_done
);

    typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;

    state_t      state;
    logic [1:0]  pkt_id;
    logic [6:0]  cnt;
    logic        is_long;
    logic [31:0] hdr0;
    logic [31:0] hdr1;

    logic        short_ok;
    logic [31:0] hdr0_nxt;
    logic [31:0] hdr1_nxt;
    logic        last;

    // Both header words are built from the live request and frozen at accept.
    always_comb begin
        short_ok = (req_len <= 7'd15) && (req_addr[29:19] == 11'd0) &&
                   (req_fst_b == 4'hF) && (req_lst_b == 4'hF);
        hdr0_nxt = short_ok ? {FMT_SHORT, req_dest, req_len[3:0], req_addr[18:0]}
                            : {FMT_LONG, req_dest, req_lst_b, req_fst_b, req_len, req_addr[29:22]};
        hdr1_nxt = {req_addr[21:0], 10'b0};
    end

    always_comb begin
        req_ready    = (state == IDLE);
        data_ready   = 1'b0;
        flit_valid   = 1'b0;
        flit.vc      = VC;
        flit.id      = pkt_id;
        flit.req     = NODE_ID;
        flit.payload = data_word;
        last         = 1'b0;
        case (state)
            HDR0: begin
                flit_valid   = 1'b1;
                flit.payload = hdr0;
                last         = !is_long && (cnt == 7'd0);
            end
            HDR1: begin
                flit_valid   = 1'b1;
                flit.payload = hdr1;
                last         = (cnt == 7'd0);
            end
            DATA: begin
                flit_valid = data_valid;
                data_ready = flit_ready;
                last       = (cnt == 7'd1);
            end
            default: ;
        endcase
        pkt_done = flit_valid && flit_ready && last;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            pkt_id  <= 2'd0;
            cnt     <= 7'd0;
            is_long <= 1'b0;
            hdr0    <= 32'd0;
            hdr1    <= 32'd0;
        end else begin
            if (pkt_done)
                pkt_id <= pkt_id + 2'd1;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt     <= req_len;
                        is_long <= !short_ok;
                        hdr0    <= hdr0_nxt;
                        hdr1    <= hdr1_nxt;
                        state   <= HDR0;
                    end
                end
                HDR0: begin
                    if (flit_ready) begin
                        if (is_long)
                            state <= HDR1;
                        else
                            state <= (cnt != 7'd0) ? DATA : IDLE;
                    end
                end
                HDR1: begin
                    if (flit_ready)
                        state <= (cnt != 7'd0) ? DATA : IDLE;
                end
                DATA: begin
                    if (data_valid && flit_ready) begin
                        cnt <= cnt - 7'd1;
                        if (cnt == 7'd1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flit_packetizer.sv
// Bench for flit_packetizer: per-cycle queue model of expected flits, hand-computed header table,
// directed reset/backpressure sequences and randomized traffic.
module tb_flit_packetizer;
    import flit_packetizer_pkg::*;

    localparam logic [4:0] TB_NODE = 5'd19;
    localparam logic       TB_VC   = 1'b1;
    localparam logic [3:0] F_LONG  = 4'h1;
    localparam logic [3:0] F_SHORT = 4'h2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        req_valid, req_ready;
    logic [4:0]  req_dest;
    logic [29:0] req_addr;
    logic [6:0]  req_len;
    logic [3:0]  req_fst_b, req_lst_b;
    logic        data_valid, data_ready;
    logic [31:0] data_word;
    logic        flit_valid, flit_ready;
    flit_t       flit;
    logic        pkt_done;

    always #5 CLK = ~CLK;

    flit_packetizer #(.NODE_ID(TB_NODE), .VC(TB_VC), .FMT_LONG(F_LONG), .FMT_SHORT(F_SHORT)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest), .req_addr(req_addr),
        .req_len(req_len), .req_fst_b(req_fst_b), .req_lst_b(req_lst_b),
        .data_valid(data_valid), .data_ready(data_ready), .data_word(data_word),
        .flit_valid(flit_valid), .flit_ready(flit_ready), .flit(flit), .pkt_done(pkt_done)
    );

    typedef struct {
        logic [4:0] dest; logic [29:0] addr; logic [6:0] len; logic [3:0] fst, lst;
        logic [31:0] h0, h1; logic lng;
    } req_t;
    typedef struct { logic [31:0] payload; logic [1:0] id; logic hdr; logic last; } exp_t;
    typedef struct {
        logic [4:0] dest; logic [29:0] addr; logic [6:0] len; logic [3:0] fst, lst;
        logic [31:0] h0, h1; logic lng; int nflits;
    } vec_t;

    req_t        req_q[$];
    exp_t        exp_q[$];
    logic [31:0] data_q[$];
    int          n_checks = 0, n_errors = 0;
    int          flit_cnt, done_cnt, stall_cnt, fr_pct, dv_pct, rq_pct;
    logic [1:0]  model_id;
    bit          rst_req;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic req_t model_req(logic [4:0] dest, logic [29:0] addr, logic [6:0] len,
                                       logic [3:0] fst, logic [3:0] lst);
        req_t r;
        logic shrt;
        shrt = (len <= 15) && (addr < 30'h80000) && (fst == 4'hF) && (lst == 4'hF);
        r.dest = dest; r.addr = addr; r.len = len; r.fst = fst; r.lst = lst;
        r.lng  = !shrt;
        r.h0   = shrt ? {F_SHORT, dest, len[3:0], addr[18:0]}
                      : {F_LONG, dest, lst, fst, len, 8'(addr >> 22)};
        r.h1   = {2'b00, addr} << 10;
        return r;
    endfunction

    task automatic sample();
        exp_t e = '{default: '0};
        bit   empty = (exp_q.size() == 0);
        logic efv;
        req_t r;
        logic [31:0] w;
        if (!empty) e = exp_q[0];
        efv = empty ? 1'b0 : (e.hdr ? 1'b1 : data_valid);
        check("flit_valid", 32'(flit_valid), 32'(efv));
        check("req_ready", 32'(req_ready), 32'(empty));
        check("data_ready", 32'(data_ready), 32'(!empty && !e.hdr && flit_ready));
        check("pkt_done", 32'(pkt_done), 32'(efv && flit_ready && e.last));
        if (efv) begin
            check("flit_payload", flit.payload, e.payload);
            check("flit_id", 32'(flit.id), 32'(e.id));
            check("flit_vc", 32'(flit.vc), 32'(TB_VC));
            check("flit_req", 32'(flit.req), 32'(TB_NODE));
        end
        if (efv && flit_ready) begin
            void'(exp_q.pop_front());
            flit_cnt++;
            if (e.last) begin
                done_cnt++;
                model_id++;
            end
        end
        if (data_valid && data_ready && data_q.size() > 0) void'(data_q.pop_front());
        if (req_valid && req_ready && req_q.size() > 0) begin
            r = req_q.pop_front();
            exp_q.push_back('{payload: r.h0, id: model_id, hdr: 1'b1, last: (!r.lng && r.len == 0)});
            if (r.lng)
                exp_q.push_back('{payload: r.h1, id: model_id, hdr: 1'b1, last: (r.len == 0)});
            for (int i = 0; i < int'(r.len); i++) begin
                w = $urandom;
                data_q.push_back(w);
                exp_q.push_back('{payload: w, id: model_id, hdr: 1'b0, last: (i == int'(r.len) - 1)});
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
        if (rst_req) begin
            nRST = 1'b0; req_valid = 1'b0; data_valid = 1'b0; flit_ready = 1'b0;
            req_q.delete(); exp_q.delete(); data_q.delete();
            model_id = 2'd0;
        end else begin
            nRST = 1'b1;
            if (req_q.size() > 0 && $urandom_range(99) < rq_pct) begin
                req_valid = 1'b1;
                req_dest = req_q[0].dest; req_addr = req_q[0].addr; req_len = req_q[0].len;
                req_fst_b = req_q[0].fst; req_lst_b = req_q[0].lst;
            end else begin
                req_valid = 1'b0;
                req_dest = 5'($urandom); req_addr = 30'($urandom); req_len = 7'($urandom);
                req_fst_b = 4'($urandom); req_lst_b = 4'($urandom);
            end
            if (data_q.size() > 0 && $urandom_range(99) < dv_pct) begin
                data_valid = 1'b1;
                data_word  = data_q[0];
            end else begin
                data_valid = 1'b0;
                data_word  = $urandom;
            end
            if (stall_cnt > 0) begin
                flit_ready = 1'b0;
                stall_cnt--;
            end else begin
                flit_ready = ($urandom_range(99) < fr_pct);
            end
        end
        @(negedge CLK);
        if (rst_req) rst_req = 1'b0;
        else sample();
    endtask

    task automatic drain(input int limit);
        int i = 0;
        while ((req_q.size() > 0 || exp_q.size() > 0) && i < limit) begin
            cycle();
            i++;
        end
        check("drain_timeout", 32'(req_q.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        req_t r;
        int   sz;
        logic [29:0] a;
        vecs[0] = '{5'd3,  30'h100,      7'd2,  4'hF, 4'hF, 32'h21900100, 32'h0,        1'b0, 3};
        vecs[1] = '{5'd7,  30'h3FFFFFFF, 7'd1,  4'h3, 4'hF, 32'h13F981FF, 32'hFFFFFC00, 1'b1, 3};
        vecs[2] = '{5'd9,  30'h7FFFF,    7'd0,  4'hF, 4'hF, 32'h2487FFFF, 32'h0,        1'b0, 1};
        vecs[3] = '{5'd0,  30'h0,        7'd16, 4'hF, 4'hF, 32'h107F9000, 32'h0,        1'b1, 18};
        vecs[4] = '{5'd31, 30'h7FFFF,    7'd15, 4'hF, 4'hF, 32'h2FFFFFFF, 32'h0,        1'b0, 16};
        vecs[5] = '{5'd0,  30'h80000,    7'd0,  4'hF, 4'hF, 32'h107F8000, 32'h20000000, 1'b1, 2};
        vecs[6] = '{5'd4,  30'h10,       7'd1,  4'hF, 4'hE, 32'h12778100, 32'h00004000, 1'b1, 3};

        nRST = 1'b0; req_valid = 1'b0; req_dest = '0; req_addr = '0; req_len = '0;
        req_fst_b = '0; req_lst_b = '0; data_valid = 1'b0; data_word = '0; flit_ready = 1'b0;
        fr_pct = 100; dv_pct = 100; rq_pct = 100; stall_cnt = 0; model_id = 2'd0;
        flit_cnt = 0; done_cnt = 0;

        rst_req = 1'b1; cycle();
        rst_req = 1'b1; cycle();
        cycle();
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_flit_valid", 32'(flit_valid), 32'd0);
        check("reset_data_ready", 32'(data_ready), 32'd0);
        check("reset_pkt_done", 32'(pkt_done), 32'd0);

        // Hand-computed header vectors; first five also walk the packet ID through its wrap.
        fr_pct = 70; dv_pct = 70; rq_pct = 80;
        for (int v = 0; v < 7; v++) begin
            flit_cnt = 0; done_cnt = 0;
            r.dest = vecs[v].dest; r.addr = vecs[v].addr; r.len = vecs[v].len;
            r.fst = vecs[v].fst; r.lst = vecs[v].lst;
            r.h0 = vecs[v].h0; r.h1 = vecs[v].h1; r.lng = vecs[v].lng;
            req_q.push_back(r);
            drain(500);
            check($sformatf("vec%0d_nflits", v), 32'(flit_cnt), 32'(vecs[v].nflits));
            check($sformatf("vec%0d_ndone", v), 32'(done_cnt), 32'd1);
        end

        // Reset after two of four data flits; the next packet must restart at ID 0.
        fr_pct = 100; dv_pct = 100; rq_pct = 100; flit_cnt = 0;
        req_q.push_back(model_req(5'd1, 30'h4, 7'd4, 4'hF, 4'hF));
        for (int i = 0; i < 50 && flit_cnt < 3; i++) cycle();
        check("rst_pre_flits", 32'(flit_cnt), 32'd3);
        rst_req = 1'b1; cycle();
        cycle();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_flit_valid", 32'(flit_valid), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        flit_cnt = 0; done_cnt = 0;
        req_q.push_back(model_req(5'd2, 30'h200, 7'd3, 4'hF, 4'hF));
        drain(200);
        check("rst_fresh_nflits", 32'(flit_cnt), 32'd4);
        check("rst_fresh_ndone", 32'(done_cnt), 32'd1);

        // Five-cycle stalls in HDR0 and in DATA.
        flit_cnt = 0;
        req_q.push_back(model_req(5'd3, 30'h100, 7'd2, 4'hF, 4'hF));
        for (int i = 0; i < 20 && exp_q.size() == 0; i++) cycle();
        stall_cnt = 5;
        repeat (5) cycle();
        check("bp_hdr_held", 32'(flit_cnt), 32'd0);
        cycle();
        check("bp_hdr_sent", 32'(flit_cnt), 32'd1);
        stall_cnt = 5;
        sz = data_q.size();
        repeat (5) cycle();
        check("bp_data_held", 32'(data_q.size()), 32'(sz));
        check("bp_data_flits", 32'(flit_cnt), 32'd1);
        drain(100);
        check("bp_total_flits", 32'(flit_cnt), 32'd3);

        // Randomized traffic in bursts with varying handshake densities.
        for (int b = 0; b < 6; b++) begin
            fr_pct = $urandom_range(30, 100);
            dv_pct = $urandom_range(30, 100);
            rq_pct = $urandom_range(30, 100);
            for (int p = 0; p < 8; p++) begin
                case ($urandom_range(2))
                    0: a = 30'($urandom_range(30'h7FFFF));
                    1: a = 30'($urandom);
                    default: a = 30'h80000 | 30'($urandom_range(30'hFFFF));
                endcase
                req_q.push_back(model_req(5'($urandom), a,
                    ($urandom_range(9) == 0) ? 7'($urandom_range(127)) : 7'($urandom_range(17)),
                    ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF,
                    ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF));
            end
            drain(8000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
